// File: rtl/spi_control_rx_pkg.sv
// Shared types and defaults for the SPI receive controller.
package spi_control_rx_pkg;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } rx_state_e;
endpackage

// File: rtl/spi_rx_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset value.
module spi_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_control_rx.sv
// SPI receive controller: deserialises LSB-first words from SCLK/SS/MOSI into the RX FIFO.
// Optional SPI_RX_FRAME_ERR_EN adds a sticky frame_err flag for frames aborted mid-word.
module spi_control_rx
  import spi_control_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  input  logic                  enable,
  input  logic                  fifo_rx_full,
  output logic                  fifo_rx_write,
  output logic [DATA_WIDTH-1:0] fifo_rx_data_in,
  output logic                  busy,
  output logic                  overflow,
`ifdef SPI_RX_FRAME_ERR_EN
  output logic                  frame_err,
`endif
  input  logic                  clear_ovf
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic sclk_s, ss_s, mosi_s;
  logic sclk_s_d_q;
  logic sclk_rise;

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         bit_cntr_q, bit_cntr_d;
  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overflow_q, overflow_d;
`ifdef SPI_RX_FRAME_ERR_EN
  logic                  frame_err_q, frame_err_d;
`endif

  // Idle-high lines reset to 1 so no spurious edge appears out of reset.
  spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (.gclk(CLK), .grst_n(RST_N), .d(SCLK), .q(sclk_s));
  spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss   (.gclk(CLK), .grst_n(RST_N), .d(SS),   .q(ss_s));
  spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.gclk(CLK), .grst_n(RST_N), .d(MOSI), .q(mosi_s));

  assign sclk_rise = sclk_s & ~sclk_s_d_q;

  always_comb begin
    state_d     = state_q;
    bit_cntr_d  = bit_cntr_q;
    shift_reg_d = shift_reg_q;
    wr_d        = 1'b0;
    data_d      = data_q;
    overflow_d  = overflow_q & ~clear_ovf;
`ifdef SPI_RX_FRAME_ERR_EN
    frame_err_d = frame_err_q & ~clear_ovf;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable && !ss_s) begin
          state_d    = ST_SHIFT;
          bit_cntr_d = '0;
        end
      end
      ST_SHIFT: begin
        if (ss_s || !enable) begin
          state_d = ST_IDLE;
`ifdef SPI_RX_FRAME_ERR_EN
          if (ss_s && bit_cntr_q != '0) frame_err_d = 1'b1;
`endif
        end else if (sclk_rise) begin
          shift_reg_d[bit_cntr_q] = mosi_s;
          if (bit_cntr_q == LAST) begin
            bit_cntr_d = '0;
            state_d    = ST_PUSH;
          end else begin
            bit_cntr_d = bit_cntr_q + CW'(1);
          end
        end
      end
      ST_PUSH: begin
        if (!fifo_rx_full) begin
          wr_d   = 1'b1;
          data_d = shift_reg_q;
        end else begin
          overflow_d = 1'b1;
        end
        bit_cntr_d = '0;
        state_d    = (!ss_s && enable) ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      bit_cntr_q  <= '0;
      shift_reg_q <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      sclk_s_d_q  <= 1'b1;
`ifdef SPI_RX_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cntr_q  <= bit_cntr_d;
      shift_reg_q <= shift_reg_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      sclk_s_d_q  <= sclk_s;
`ifdef SPI_RX_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign fifo_rx_write   = wr_q;
  assign fifo_rx_data_in = data_q;
  assign busy            = (state_q != ST_IDLE);
  assign overflow        = overflow_q;
`ifdef SPI_RX_FRAME_ERR_EN
  assign frame_err       = frame_err_q;
`endif
endmodule
